// File: rtl/led_pattern_master_if.sv
// led_pattern_master_if: Avalon-MM master/slave bundle between the LED pattern master and the PIO slave.
interface led_pattern_master_if #(
  parameter int ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_write;
  logic [31:0]           avm_writedata;
  logic                  avm_read;
  logic [31:0]           avm_readdata;
  logic                  avm_readdatavalid;
  logic                  avm_waitrequest;
  modport master (
    output avm_address, avm_write, avm_writedata, avm_read,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );
  modport slave (
    input  avm_address, avm_write, avm_writedata, avm_read,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/led_pattern_master.sv
// led_pattern_master: tick-paced Avalon-MM writer of a bouncing one-hot LED pattern.
// Optional readback compare enabled by LED_PATTERN_MASTER_READBACK_EN.
module led_pattern_master #(
  parameter int LED_WIDTH = 6,
  parameter int DIV_WIDTH = 26,
  parameter int ADDR_WIDTH = 2,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  led_pattern_master_if.master bus,
  output logic                 busy,
  output logic [15:0]          write_count,
  output logic                 mismatch
);
`ifdef LED_PATTERN_MASTER_READBACK_EN
  typedef enum logic [2:0] {IDLE, WAIT_TICK, WRITE, READ, READ_WAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_TICK, WRITE} state_t;
`endif
  state_t               state;
  logic [DIV_WIDTH-1:0] cnt, last;
  logic [LED_WIDTH-1:0] pattern, nxt_pat;
  logic                 dir, nxt_dir;
  logic                 rd_bad;
  // dir: 0 = LEFT, 1 = RIGHT; turn around when the lit bit reaches an end
  always_comb begin
    last    = (period == '0) ? '0 : period - 1'b1;
    nxt_dir = dir ? !pattern[0] : pattern[LED_WIDTH-1];
    nxt_pat = nxt_dir ? pattern >> 1 : pattern << 1;
    rd_bad  = bus.avm_readdata[LED_WIDTH-1:0] != bus.avm_writedata[LED_WIDTH-1:0];
  end
  assign bus.avm_address = TARGET_ADDR;
`ifndef LED_PATTERN_MASTER_READBACK_EN
  logic unused_rd;
  assign unused_rd     = rd_bad ^ bus.avm_readdatavalid;
  assign bus.avm_read  = 1'b0;
  assign mismatch      = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      pattern           <= LED_WIDTH'(1);
      dir               <= 1'b0;
      bus.avm_write     <= 1'b0;
      bus.avm_writedata <= '0;
      busy              <= 1'b0;
      write_count       <= '0;
`ifdef LED_PATTERN_MASTER_READBACK_EN
      bus.avm_read      <= 1'b0;
      mismatch          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (enable) begin
          state <= WAIT_TICK;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        WAIT_TICK: if (!enable) begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end else if (cnt == last) begin
          state             <= WRITE;
          cnt               <= '0;
          bus.avm_write     <= 1'b1;
          bus.avm_writedata <= 32'(pattern);
        end else begin
          cnt <= cnt + 1'b1;
        end
        // writedata is held after acceptance so readback can compare against it
        WRITE: if (!bus.avm_waitrequest) begin
          bus.avm_write <= 1'b0;
          write_count   <= write_count + 1'b1;
          pattern       <= nxt_pat;
          dir           <= nxt_dir;
`ifdef LED_PATTERN_MASTER_READBACK_EN
          state         <= READ;
          bus.avm_read  <= 1'b1;
`else
          state         <= enable ? WAIT_TICK : IDLE;
          busy          <= enable;
`endif
        end
`ifdef LED_PATTERN_MASTER_READBACK_EN
        READ: if (!bus.avm_waitrequest) begin
          bus.avm_read <= 1'b0;
          if (bus.avm_readdatavalid) begin
            mismatch <= mismatch | rd_bad;
            state    <= enable ? WAIT_TICK : IDLE;
            busy     <= enable;
          end else begin
            state <= READ_WAIT;
          end
        end
        READ_WAIT: if (bus.avm_readdatavalid) begin
          mismatch <= mismatch | rd_bad;
          state    <= enable ? WAIT_TICK : IDLE;
          busy     <= enable;
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_pattern_master.sv
// tb_led_pattern_master: directed table-driven bench for led_pattern_master.
module tb_led_pattern_master;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [25:0] period;
  logic        busy;
  logic [15:0] write_count;
  logic        mismatch;
  logic [31:0] mem;
  int          rd_n;
  int          corrupt_at = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  led_pattern_master_if #(.ADDR_WIDTH(2)) bus();
  led_pattern_master dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period), .bus(bus),
    .busy(busy), .write_count(write_count), .mismatch(mismatch)
  );
  always #5 clk = ~clk;
  // echoing slave; optionally flips bit 2 on the chosen readback
  always @(posedge clk) begin
    if (reset) begin
      mem  <= '0;
      rd_n <= 0;
      bus.avm_readdatavalid <= 1'b0;
      bus.avm_readdata <= '0;
    end else begin
      if (bus.avm_write && !bus.avm_waitrequest) mem <= bus.avm_writedata;
      bus.avm_readdatavalid <= bus.avm_read && !bus.avm_waitrequest;
      if (bus.avm_read && !bus.avm_waitrequest) begin
        rd_n <= rd_n + 1;
        bus.avm_readdata <= (rd_n + 1 == corrupt_at) ? (mem ^ 32'h4) : mem;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    bus.avm_waitrequest = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask
  task automatic wait_write(output int w, output bit ok);
    w = 0;
    do begin
      step();
      w++;
    end while (!bus.avm_write && w < 200);
    ok = bus.avm_write;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_write: no avm_write within %0d cycles", w);
    end
  endtask
  typedef struct {
    logic [25:0] period;
    int          n;
    int          first;
    int          gap;
  } vec_t;
  vec_t        vt[3];
  logic [5:0]  seq[12];
  int          w, t, nw;
  bit          ok;
  initial begin
    vt[0] = '{26'd4, 12, 5, 5};
    vt[1] = '{26'd0, 8, 2, 2};
    vt[2] = '{26'd1, 8, 2, 2};
    seq = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01, 6'h02};
    period = 26'd4;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_write", bus.avm_write, 0);
    chk("rst_read", bus.avm_read, 0);
    chk("rst_wdata", bus.avm_writedata, 0);
    chk("rst_count", write_count, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_addr", bus.avm_address, 0);
`ifndef LED_PATTERN_MASTER_READBACK_EN
    for (int r = 0; r < 3; r++) begin
      do_reset();
      period = vt[r].period;
      enable = 1'b1;
      t = 0;
      for (int k = 0; k < vt[r].n; k++) begin
        wait_write(w, ok);
        t += w;
        if (ok) begin
          chk("wr_cycle", t, vt[r].first + k * vt[r].gap);
          chk("wr_data", bus.avm_writedata, 32'(seq[k]));
        end
      end
      step();
      chk("wr_count", write_count, vt[r].n);
      chk("wr_busy", busy, 1);
    end
    do_reset();
    period = 26'd1;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) wait_write(w, ok);
    chk("stall_data0", bus.avm_writedata, 32'h04);
    bus.avm_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_write", bus.avm_write, 1);
      chk("stall_data", bus.avm_writedata, 32'h04);
      chk("stall_count", write_count, 2);
    end
    bus.avm_waitrequest = 1'b0;
    step();
    chk("stall_drop", bus.avm_write, 0);
    chk("stall_count1", write_count, 3);
    wait_write(w, ok);
    chk("stall_next", bus.avm_writedata, 32'h08);
    do_reset();
    period = 26'd2;
    enable = 1'b1;
    wait_write(w, ok);
    bus.avm_waitrequest = 1'b1;
    enable = 1'b0;
    step();
    chk("drop_hold", bus.avm_write, 1);
    chk("drop_busy", busy, 1);
    bus.avm_waitrequest = 1'b0;
    step();
    chk("drop_write", bus.avm_write, 0);
    chk("drop_idle", busy, 0);
    chk("drop_count", write_count, 1);
    nw = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      nw += int'(bus.avm_write);
    end
    chk("drop_nowrites", nw, 0);
    chk("drop_count2", write_count, 1);
    do_reset();
    period = 26'd4;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) wait_write(w, ok);
    step();
    step();
    reset = 1'b1;
    step();
    chk("mrst_write", bus.avm_write, 0);
    chk("mrst_count", write_count, 0);
    chk("mrst_busy", busy, 0);
    reset = 1'b0;
    wait_write(w, ok);
    chk("mrst_cycle", w, 5);
    chk("mrst_data", bus.avm_writedata, 32'h01);
`else
    corrupt_at = 0;
    do_reset();
    period = 26'd1;
    enable = 1'b1;
    t = 0;
    while (write_count != 16'd20 && t < 500) begin
      step();
      t++;
    end
    chk("rb_count", write_count, 20);
    chk("rb_clean", mismatch, 0);
    corrupt_at = 5;
    do_reset();
    enable = 1'b1;
    t = 0;
    while (!(bus.avm_readdatavalid && rd_n == 5) && t < 500) begin
      step();
      t++;
    end
    chk("rb_seen5", rd_n, 5);
    chk("rb_before", mismatch, 0);
    step();
    chk("rb_set", mismatch, 1);
    for (int k = 0; k < 10; k++) step();
    chk("rb_sticky", mismatch, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/led_pattern_master.md
Name: led_pattern_master

Overview:
- Avalon-MM initiator that drives the LED PIO slave (register offset 0) from the fabric side, so no HPS software is needed to animate the LEDs.
- A programmable tick divider paces the block. On each tick it issues one single-word write carrying the next pattern of a one-hot "bouncing" LED sequence.
- Sits in the FPGA fabric, on the same clock domain as the PIO, connected as a master on the PIO's slave port.

Parameters:
- LED_WIDTH, 6, number of LED bits driven; pattern occupies writedata[LED_WIDTH-1:0].
- DIV_WIDTH, 26, width of the tick period input/counter.
- ADDR_WIDTH, 2, width of avm_address (word address of target register).
- TARGET_ADDR, 0, word address written (PIO data register).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- period  in  DIV_WIDTH  clk cycles per tick; value 0 treated as 1.
- avm_address  out  ADDR_WIDTH  master address.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data; bits above LED_WIDTH are 0.
- avm_read  out  1  read request (readback feature only, else constant 0).
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read response strobe.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high whenever state != IDLE.
- write_count  out  16  accepted writes since reset; wraps 0xFFFF->0x0000.
- mismatch  out  1  sticky readback-compare error (feature only, else 0).

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high, sampled on the rising edge of clk. Asserting reset mid-transaction aborts immediately; the next edge forces all state to its reset value.
- Reset values:
  - state=IDLE, tick counter=0, pattern=1 (bit0), dir=LEFT.
  - avm_write=0, avm_read=0, avm_address=TARGET_ADDR, avm_writedata=0.
  - busy=0, write_count=0, mismatch=0.
- States: IDLE, WAIT_TICK, WRITE, READ, READ_WAIT. READ and READ_WAIT exist only with the feature enabled.
- IDLE:
  - enable=1 -> WAIT_TICK with counter cleared to 0.
- WAIT_TICK:
  - Counter increments each cycle.
  - When counter == max(period,1)-1: go to WRITE and clear counter.
  - The first write therefore starts max(period,1) cycles after entry. period=1 gives back-to-back ticks.
  - enable=0 in WAIT_TICK -> IDLE next cycle; counter cleared.
- WRITE:
  - avm_write=1 and avm_writedata={0, pattern} are registered outputs, held stable while avm_waitrequest=1.
  - A write is accepted on the cycle avm_write=1 and avm_waitrequest=0.
  - On acceptance: avm_write drops next cycle, write_count increments, and the pattern advances.
  - Next state: READ if feature enabled; else WAIT_TICK if enable=1, else IDLE.
  - enable deasserting during WRITE does not abort; the transaction completes first (Avalon hold rule).
- Pattern advance (one-hot bounce):
  - dir=LEFT: if pattern[LED_WIDTH-1]=1, set dir=RIGHT and shift right; else shift left.
  - dir=RIGHT: if pattern[0]=1, set dir=LEFT and shift left; else shift right.
  - Sequence for LED_WIDTH=6: 01,02,04,08,10,20,10,08,04,02,01,02,…
  - The endpoints 0x01 and 0x20 are each written once per bounce, never twice in a row.
- Counter during writes: the tick counter does not run outside WAIT_TICK. A long waitrequest stretches the period; ticks are never queued.
- busy: registered, equal to (state != IDLE).

Optional Feature:
- Macro: LED_PATTERN_MASTER_READBACK_EN.
- When defined, after each accepted write:
  - READ: assert avm_read at TARGET_ADDR until waitrequest=0.
  - READ_WAIT: wait for avm_readdatavalid. Compare avm_readdata[LED_WIDTH-1:0] against the value just written; inequality sets mismatch (sticky until reset). Then go to WAIT_TICK or IDLE per enable.
  - avm_readdatavalid arriving on the same cycle the read is accepted is legal and handled.
- When undefined: READ and READ_WAIT are not built; avm_read tied 0; mismatch tied 0; avm_readdata and avm_readdatavalid unused.

Test Plan:
- Reset then enable=1, period=4, waitrequest=0 -> first avm_write pulse 4 cycles after the enable edge, writedata=0x01; subsequent writes every 5 cycles (4 wait + 1 write); writedata sequence 01,02,04,08,10,20,10,08,04,02,01,02.
- period=0 and period=1 -> identical behaviour: one write every 2 cycles; write_count reaches 8 after 8 accepts.
- waitrequest held high 3 cycles during a write -> avm_write and writedata=0x04 stable for all 4 cycles; write_count increments once; pattern advances once.
- enable dropped in the cycle avm_write asserts while waitrequest=1 -> write completes, then IDLE, busy=0; no further writes.
- reset pulsed mid-WAIT_TICK after 3 writes -> next cycle pattern=0x01, write_count=0, avm_write=0; with enable still high, restart writes 0x01 after period cycles.
- With LED_PATTERN_MASTER_READBACK_EN: a slave model echoes data -> mismatch=0 over 20 writes. The model corrupts bit 2 on the 5th readback -> mismatch=1 from the cycle after that readdatavalid and stays 1.
